// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - state encoding and default geometry for the hazard grid rasterizer
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_COORD_W     = 5;
  localparam int DEF_ROWS        = 4;
  localparam int DEF_COLS        = 8;
  localparam int DEF_CELL_H_LOG2 = 1;
  localparam int DEF_CELL_W_LOG2 = 2;
  localparam int DEF_MAX_HAZ     = 16;

endpackage

// File: rtl/box_to_mask.sv
// rtl/box_to_mask.sv - combinational mapping of one inclusive hazard box onto the cell grid
module box_to_mask
  import hazard_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int CELL_H_LOG2 = DEF_CELL_H_LOG2,
  parameter int CELL_W_LOG2 = DEF_CELL_W_LOG2
) (
  input  logic [COORD_W-1:0]   top_i,
  input  logic [COORD_W-1:0]   left_i,
  input  logic [COORD_W-1:0]   bottom_i,
  input  logic [COORD_W-1:0]   right_i,
  output logic [ROWS*COLS-1:0] mask_o,
  output logic                 bad_o
);

  logic [COORD_W-1:0] row_lo, row_hi, col_lo, col_hi;

  assign row_lo = top_i >> CELL_H_LOG2;
  assign row_hi = bottom_i >> CELL_H_LOG2;
  assign col_lo = left_i >> CELL_W_LOG2;
  assign col_hi = right_i >> CELL_W_LOG2;

  assign bad_o = (bottom_i < top_i) || (right_i < left_i);

  // Only cells inside the grid are enumerated, so out-of-range indices clip away naturally.
  always_comb begin
    mask_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mask_o[r*COLS + c] = (r >= int'(row_lo)) && (r <= int'(row_hi)) &&
                             (c >= int'(col_lo)) && (c <= int'(col_hi));
      end
    end
  end

endmodule

// File: rtl/hazard_grid_rasterizer.sv
// rtl/hazard_grid_rasterizer.sv - accumulates per-frame hazard boxes into a cell occupancy map
module hazard_grid_rasterizer
  import hazard_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int CELL_H_LOG2 = DEF_CELL_H_LOG2,
  parameter int CELL_W_LOG2 = DEF_CELL_W_LOG2,
  parameter int MAX_HAZ     = DEF_MAX_HAZ
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           haz_valid,
  output logic                           haz_ready,
  input  logic [COORD_W-1:0]             haz_top,
  input  logic [COORD_W-1:0]             haz_left,
  input  logic [COORD_W-1:0]             haz_bottom,
  input  logic [COORD_W-1:0]             haz_right,
  input  logic                           frame_end,
  output logic                           grid_valid,
  input  logic                           grid_ready,
  output logic [ROWS*COLS-1:0]           grid_out,
  output logic [$clog2(MAX_HAZ+1)-1:0]   haz_count,
  output logic                           overflow,
  output logic                           bad_box
);

  localparam int CNT_W = $clog2(MAX_HAZ + 1);
  localparam int CELLS = ROWS * COLS;

  state_e             state_q, state_d;
  logic [CELLS-1:0]   grid_q, grid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               bad_q, bad_d;

  logic [CELLS-1:0]   box_mask;
  logic               box_bad;
  logic               accept;
  logic               full;

  box_to_mask #(
    .COORD_W     (COORD_W),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .CELL_H_LOG2 (CELL_H_LOG2),
    .CELL_W_LOG2 (CELL_W_LOG2)
  ) u_box_to_mask (
    .top_i    (haz_top),
    .left_i   (haz_left),
    .bottom_i (haz_bottom),
    .right_i  (haz_right),
    .mask_o   (box_mask),
    .bad_o    (box_bad)
  );

  assign accept = haz_valid && (state_q == ST_ACCUM);
  assign full   = (cnt_q == CNT_W'(MAX_HAZ));

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          grid_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Malformed boxes are flagged before the capacity check so they never count as drops.
        if (accept) begin
          if (box_bad) begin
            bad_d = 1'b1;
          end else if (full) begin
            ovf_d = 1'b1;
          end else begin
            grid_d = grid_q | box_mask;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        if (frame_end) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (grid_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grid_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign haz_ready  = (state_q == ST_ACCUM);
  assign grid_valid = (state_q == ST_HOLD);
  assign grid_out   = grid_q;
  assign haz_count  = cnt_q;
  assign overflow   = ovf_q;
  assign bad_box    = bad_q;

endmodule

// File: tb/tb_hazard_grid_rasterizer.sv
// tb/tb_hazard_grid_rasterizer.sv - scoreboard bench for the hazard grid rasterizer
module tb_hazard_grid_rasterizer;

  typedef struct packed {
    logic [31:0] grid;
    logic [4:0]  cnt;
    logic        ovf;
    logic        bad;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, haz_valid, haz_ready, frame_end;
  logic        grid_valid, grid_ready, overflow, bad_box;
  logic [4:0]  haz_top, haz_left, haz_bottom, haz_right, haz_count;
  logic [31:0] grid_out;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen_valid = 0;

  always #5 clk = ~clk;

  hazard_grid_rasterizer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .haz_valid   (haz_valid),
    .haz_ready   (haz_ready),
    .haz_top     (haz_top),
    .haz_left    (haz_left),
    .haz_bottom  (haz_bottom),
    .haz_right   (haz_right),
    .frame_end   (frame_end),
    .grid_valid  (grid_valid),
    .grid_ready  (grid_ready),
    .grid_out    (grid_out),
    .haz_count   (haz_count),
    .overflow    (overflow),
    .bad_box     (bad_box)
  );

  // Scoreboard: each new result window pops one expectation.
  always @(negedge clk) begin
    res_t e;
    if (!grid_valid) begin
      seen_valid = 0;
    end else if (!seen_valid) begin
      seen_valid = 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got grid=%h cnt=%0d, required no result", grid_out, haz_count);
      end else begin
        e = exp_q.pop_front();
        if ({grid_out, haz_count, overflow, bad_box} !== e) begin
          errors++;
          $display("FAIL scoreboard: got grid=%h cnt=%0d ovf=%b bad=%b, required grid=%h cnt=%0d ovf=%b bad=%b",
                   grid_out, haz_count, overflow, bad_box, e.grid, e.cnt, e.ovf, e.bad);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] g, input logic [4:0] c, input logic o, input logic b);
    res_t e;
    e.grid = g; e.cnt = c; e.ovf = o; e.bad = b;
    exp_q.push_back(e);
  endtask

  task automatic start_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_box(input logic [4:0] t, input logic [4:0] l, input logic [4:0] b,
                          input logic [4:0] r, input logic fe);
    haz_valid = 1'b1;
    haz_top = t; haz_left = l; haz_bottom = b; haz_right = r;
    frame_end = fe;
    tick();
    haz_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic end_frame;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic release_result;
    int n = 0;
    while (grid_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (grid_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: got grid_valid=%b, required 1 within 20 cycles", grid_valid);
    end
    grid_ready = 1'b1;
    tick();
    grid_ready = 1'b0;
  endtask

  function automatic logic [31:0] model_mask(input int t, input int l, input int b, input int r);
    logic [31:0] m = '0;
    for (int row = t / 2; row <= b / 2; row++)
      for (int col = l / 4; col <= r / 4; col++)
        if (row < 4 && col < 8) m[row*8 + col] = 1'b1;
    return m;
  endfunction

  task automatic test_reset;
    checks++;
    if ({grid_out, haz_count, overflow, bad_box, haz_ready, grid_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grid=%h cnt=%0d ovf=%b bad=%b rdy=%b gv=%b, required all 0",
               grid_out, haz_count, overflow, bad_box, haz_ready, grid_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (haz_ready !== 1'b0 || grid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b gv=%b, required 0 0", haz_ready, grid_valid);
    end
  endtask

  task automatic test_basic;
    start_frame();
    checks++;
    if (haz_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b, required 1", haz_ready);
    end
    send_box(0, 0, 1, 2, 0);
    checks++;
    if (grid_out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL basic_first_box: got %h, required 00000001", grid_out);
    end
    send_box(6, 23, 7, 25, 0);
    push_exp(32'h6000_0001, 5'd2, 1'b0, 1'b0);
    end_frame();
    checks++;
    if (grid_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid_latency: got grid_valid=%b, required 1", grid_valid);
    end
    release_result();
  endtask

  task automatic test_overflow;
    start_frame();
    for (int i = 0; i < 16; i++) send_box(0, 0, 0, 0, 0);
    checks++;
    if (haz_ready !== 1'b1 || haz_count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got rdy=%b cnt=%0d ovf=%b, required 1 16 0", haz_ready, haz_count, overflow);
    end
    send_box(6, 28, 7, 31, 0);
    checks++;
    if (overflow !== 1'b1 || grid_out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ovf_drop: got ovf=%b grid=%h, required 1 00000001", overflow, grid_out);
    end
    push_exp(32'h0000_0001, 5'd16, 1'b1, 1'b0);
    end_frame();
    release_result();
  endtask

  task automatic test_bad_box;
    start_frame();
    send_box(5, 0, 2, 0, 0);
    checks++;
    if (bad_box !== 1'b1 || haz_count !== 5'd0 || grid_out !== 32'h0) begin
      errors++;
      $display("FAIL bad_box: got bad=%b cnt=%0d grid=%h, required 1 0 00000000", bad_box, haz_count, grid_out);
    end
    push_exp(32'h0, 5'd0, 1'b0, 1'b1);
    end_frame();
    release_result();
  endtask

  task automatic test_clip;
    start_frame();
    send_box(8, 0, 31, 31, 0);
    checks++;
    if (grid_out !== 32'h0 || haz_count !== 5'd1) begin
      errors++;
      $display("FAIL clip_outside: got grid=%h cnt=%0d, required 00000000 1", grid_out, haz_count);
    end
    send_box(0, 0, 31, 31, 0);
    checks++;
    if (grid_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL clip_full: got %h, required ffffffff", grid_out);
    end
    push_exp(32'hFFFF_FFFF, 5'd2, 1'b0, 1'b0);
    end_frame();
    release_result();
  endtask

  task automatic test_hold;
    start_frame();
    send_box(2, 4, 3, 7, 0);
    push_exp(32'h0000_0200, 5'd1, 1'b0, 1'b0);
    end_frame();
    for (int i = 0; i < 5; i++) begin
      frame_start = 1'b1;
      tick();
      checks++;
      if (grid_out !== 32'h0000_0200 || grid_valid !== 1'b1 || haz_ready !== 1'b0 || haz_count !== 5'd1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got grid=%h gv=%b rdy=%b cnt=%0d, required 00000200 1 0 1",
                 i, grid_out, grid_valid, haz_ready, haz_count);
      end
    end
    frame_start = 1'b0;
    release_result();
    checks++;
    if (grid_valid !== 1'b0 || haz_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_to_idle: got gv=%b rdy=%b, required 0 0", grid_valid, haz_ready);
    end
    end_frame();
    checks++;
    if (grid_valid !== 1'b0 || haz_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_frame_end: got gv=%b rdy=%b, required 0 0", grid_valid, haz_ready);
    end
  endtask

  task automatic test_back_to_back;
    start_frame();
    send_box(0, 0, 0, 0, 0);
    send_box(0, 4, 0, 4, 1);
    push_exp(32'h0000_0003, 5'd2, 1'b0, 1'b0);
    checks++;
    if (grid_valid !== 1'b1 || grid_out !== 32'h0000_0003) begin
      errors++;
      $display("FAIL b2b_same_cycle: got gv=%b grid=%h, required 1 00000003", grid_valid, grid_out);
    end
    release_result();
    start_frame();
    checks++;
    if (grid_out !== 32'h0 || haz_count !== 5'd0) begin
      errors++;
      $display("FAIL b2b_cleared: got grid=%h cnt=%0d, required 00000000 0", grid_out, haz_count);
    end
    send_box(6, 28, 7, 31, 1);
    push_exp(32'h8000_0000, 5'd1, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_reset_mid;
    start_frame();
    send_box(0, 0, 31, 31, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grid_out, haz_count, overflow, bad_box, haz_ready, grid_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got grid=%h cnt=%0d ovf=%b bad=%b rdy=%b gv=%b, required all 0",
               grid_out, haz_count, overflow, bad_box, haz_ready, grid_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_frame();
    send_box(2, 8, 2, 8, 0);
    checks++;
    if (grid_out !== 32'h0000_0400) begin
      errors++;
      $display("FAIL reset_next_frame: got %h, required 00000400", grid_out);
    end
    push_exp(32'h0000_0400, 5'd1, 1'b0, 1'b0);
    end_frame();
    release_result();
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      logic [31:0] g = '0;
      logic [4:0]  c = '0;
      logic        b = 1'b0;
      int          n = $urandom_range(1, 6);
      start_frame();
      for (int k = 0; k < n; k++) begin
        int t = $urandom_range(0, 31);
        int l = $urandom_range(0, 31);
        int bo = $urandom_range(0, 31);
        int r = $urandom_range(0, 31);
        if (bo < t || r < l) begin
          b = 1'b1;
        end else begin
          g = g | model_mask(t, l, bo, r);
          c = c + 5'd1;
        end
        send_box(5'(t), 5'(l), 5'(bo), 5'(r), 0);
      end
      push_exp(g, c, 1'b0, b);
      end_frame();
      release_result();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0; haz_valid = 1'b0; grid_ready = 1'b0;
    haz_top = '0; haz_left = '0; haz_bottom = '0; haz_right = '0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_overflow();
    test_bad_box();
    test_clip();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
